fetch_sequencer: RTL and testbench

Multi-cycle instruction fetch and PC sequencing unit for the single-issue WISC processor. It owns the PC and the EPC, and fetches each instruction word from the stalling instruction memory. It presents the word to the instruction decoder and then waits for the datapath to retire it. It consumes the decoder's branch/jump/halt/exception controls (`pc_sel`, `reg_jmp`, `halt`, `siic`, `rti`) to pick the next PC, so it closes the loop on the decode interface from the fetch side.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_sequencer_pc_next_calc.sv | 44 ++++
 rtl/fetch_sequencer.sv | 126 ++++++++++++
 tb/tb_fetch_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the WISC fetch sequencer.
// Holds the sequencer state encoding, word width and default vectors.
package fetch_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 16'h0000;
    localparam logic [WORD_W-1:0] DEFAULT_SIIC_VEC = 16'h0002;
    localparam logic [WORD_W-1:0] PC_STEP          = 16'h0002;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    // Instruction words are 16-bit aligned, so bit 0 of any PC must be clear.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next_calc.sv
// Combinational next-PC selection for a retiring instruction.
// Applies the siic > rti > reg_jmp > pc_sel > sequential priority.
module pc_next_calc
    import fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] SIIC_VEC = DEFAULT_SIIC_VEC
) (
    input  logic [WORD_W-1:0] pc,
    input  logic [WORD_W-1:0] imm_ext,
    input  logic [WORD_W-1:0] rs_val,
    input  logic [WORD_W-1:0] epc,
    input  logic              siic,
    input  logic              rti,
    input  logic              reg_jmp,
    input  logic              pc_sel,
    output logic [WORD_W-1:0] pc_plus2,
    output logic [WORD_W-1:0] next_pc,
    output logic              misaligned
);

    logic [WORD_W-1:0] target;

    always_comb begin
        pc_plus2   = pc + PC_STEP;
        target     = pc_plus2;
        next_pc    = pc_plus2;
        misaligned = 1'b0;

        if (siic) begin
            next_pc = SIIC_VEC;
        end else if (rti) begin
            next_pc = epc;
        end else if (reg_jmp) begin
            target     = rs_val + imm_ext;
            misaligned = target[0];
            next_pc    = align_word(target);
        end else if (pc_sel) begin
            target     = pc_plus2 + imm_ext;
            misaligned = target[0];
            next_pc    = align_word(target);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/PC sequencer: owns PC and EPC, fetches from stalling
// instruction memory, holds the word for decode and redirects on retire.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [WORD_W-1:0] SIIC_VEC = DEFAULT_SIIC_VEC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_en,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              imem_done,
    input  logic              imem_stall,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    output logic [WORD_W-1:0] pc_plus2,
    input  logic              retire,
    input  logic              pc_sel,
    input  logic              reg_jmp,
    input  logic [WORD_W-1:0] imm_ext,
    input  logic [WORD_W-1:0] rs_val,
    input  logic              halt,
    input  logic              siic,
    input  logic              rti,
    output logic              halted,
    output logic              fetch_err
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] epc_q, epc_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic              fetch_err_q, fetch_err_d;

    logic [WORD_W-1:0] next_pc;
    logic [WORD_W-1:0] pc_inc;
    logic              misaligned;

    pc_next_calc #(
        .SIIC_VEC (SIIC_VEC)
    ) u_pc_next_calc (
        .pc         (pc_q),
        .imm_ext    (imm_ext),
        .rs_val     (rs_val),
        .epc        (epc_q),
        .siic       (siic),
        .rti        (rti),
        .reg_jmp    (reg_jmp),
        .pc_sel     (pc_sel),
        .pc_plus2   (pc_inc),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            epc_q       <= '0;
            instr_q     <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            epc_q       <= epc_d;
            instr_q     <= instr_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        epc_d       = epc_q;
        instr_d     = instr_q;
        fetch_err_d = fetch_err_q;

        unique case (state_q)
            FETCH: begin
                // A completed read wins over a coincident stall indication.
                if (imem_done) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end else if (imem_stall) begin
                    state_d = FETCH;
                end
            end
            ISSUE: begin
                if (retire) begin
                    pc_d = next_pc;
                    if (siic) begin
                        epc_d = pc_inc;
                    end
                    if (misaligned) begin
                        fetch_err_d = 1'b1;
                        state_d     = HALTED;
                    end else if (halt && !siic) begin
                        state_d = HALTED;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Status outputs are gated by rst_n so they read low for the whole reset window.
    always_comb begin
        imem_en     = rst_n && (state_q == FETCH);
        instr_valid = rst_n && (state_q == ISSUE);
        halted      = rst_n && (state_q == HALTED);
        imem_addr   = pc_q;
        instr       = instr_q;
        pc_plus2    = pc_inc;
        fetch_err   = fetch_err_q;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a scoreboard of expected fetch
// addresses is filled on each retire and drained as the memory model serves fetches.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_done;
    logic        imem_stall;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc_plus2;
    logic        retire;
    logic        pc_sel;
    logic        reg_jmp;
    logic [15:0] imm_ext;
    logic [15:0] rs_val;
    logic        halt;
    logic        siic;
    logic        rti;
    logic        halted;
    logic        fetch_err;

    int          total;
    int          bad;
    logic [15:0] expAddrQ[$];
    logic [15:0] modelPc;
    logic [15:0] modelEpc;
    logic        modelErr;

    fetch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_done   (imem_done),
        .imem_stall  (imem_stall),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc_plus2    (pc_plus2),
        .retire      (retire),
        .pc_sel      (pc_sel),
        .reg_jmp     (reg_jmp),
        .imm_ext     (imm_ext),
        .rs_val      (rs_val),
        .halt        (halt),
        .siic        (siic),
        .rti         (rti),
        .halted      (halted),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic clearControls();
        retire  = 1'b0;
        pc_sel  = 1'b0;
        reg_jmp = 1'b0;
        halt    = 1'b0;
        siic    = 1'b0;
        rti     = 1'b0;
        imm_ext = '0;
        rs_val  = '0;
    endtask

    task automatic doReset();
        rst_n      = 1'b0;
        imem_done  = 1'b0;
        imem_stall = 1'b0;
        imem_rdata = '0;
        clearControls();
        @(negedge clk);
        checkOutput("rst_imem_en", {15'd0, imem_en}, 16'd0);
        checkOutput("rst_valid", {15'd0, instr_valid}, 16'd0);
        checkOutput("rst_halted", {15'd0, halted}, 16'd0);
        checkOutput("rst_err", {15'd0, fetch_err}, 16'd0);
        checkOutput("rst_pc", imem_addr, 16'h0000);
        checkOutput("rst_instr", instr, 16'h0000);
        expAddrQ.delete();
        expAddrQ.push_back(16'h0000);
        modelPc  = 16'h0000;
        modelEpc = 16'h0000;
        modelErr = 1'b0;
        rst_n    = 1'b1;
    endtask

    // Memory model: wait for a request, stall for a number of cycles, then return data.
    task automatic serveFetch(input int stalls, input logic [15:0] data);
        logic [15:0] expAddr;
        int          waited;
        waited = 0;
        while (imem_en !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (imem_en !== 1'b1) begin
            checkOutput("fetch_timeout", {15'd0, imem_en}, 16'd1);
            return;
        end
        if (expAddrQ.size() == 0) begin
            checkOutput("sb_empty", imem_addr, 16'hDEAD);
            return;
        end
        expAddr = expAddrQ.pop_front();
        checkOutput("fetch_addr", imem_addr, expAddr);
        for (int i = 0; i < stalls; i++) begin
            imem_stall = 1'b1;
            @(negedge clk);
            checkOutput("stall_addr", imem_addr, expAddr);
            checkOutput("stall_en", {15'd0, imem_en}, 16'd1);
        end
        imem_stall = 1'b0;
        imem_done  = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_done  = 1'b0;
        checkOutput("issue_valid", {15'd0, instr_valid}, 16'd1);
        checkOutput("issue_instr", instr, data);
        checkOutput("issue_pc_plus2", pc_plus2, modelPc + 16'd2);
    endtask

    // Retire the current instruction with the given controls and predict the next PC.
    task automatic applyStimulus(input logic s, input logic r, input logic rj, input logic ps,
                                 input logic h, input logic [15:0] imm, input logic [15:0] rs);
        logic [15:0] p2;
        logic [15:0] tgt;
        logic [15:0] npc;
        logic        err;
        logic        goHalt;
        p2  = modelPc + 16'd2;
        npc = p2;
        err = 1'b0;
        if (s) begin
            modelEpc = p2;
            npc      = 16'h0002;
        end else if (r) begin
            npc = modelEpc;
        end else if (rj) begin
            tgt = rs + imm;
            err = tgt[0];
            npc = tgt & 16'hFFFE;
        end else if (ps) begin
            tgt = p2 + imm;
            err = tgt[0];
            npc = tgt & 16'hFFFE;
        end
        goHalt  = err || (h && !s);
        modelPc = npc;
        if (err) modelErr = 1'b1;
        if (!goHalt) expAddrQ.push_back(npc);

        retire  = 1'b1;
        siic    = s;
        rti     = r;
        reg_jmp = rj;
        pc_sel  = ps;
        halt    = h;
        imm_ext = imm;
        rs_val  = rs;
        @(negedge clk);
        clearControls();
        checkOutput("ret_valid", {15'd0, instr_valid}, 16'd0);
        checkOutput("ret_halted", {15'd0, halted}, {15'd0, goHalt});
        checkOutput("ret_imem_en", {15'd0, imem_en}, {15'd0, !goHalt});
        checkOutput("ret_pc", imem_addr, npc);
        checkOutput("ret_err", {15'd0, fetch_err}, {15'd0, modelErr});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        doReset();

        // Sequential flow from reset
        serveFetch(0, 16'h1111);
        applyStimulus(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        serveFetch(0, 16'h2222);
        applyStimulus(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        serveFetch(0, 16'h3333);

        // Stalled fetch at 0x0010
        applyStimulus(0, 0, 1, 0, 0, 16'h0000, 16'h0010);
        serveFetch(3, 16'hC0A5);

        // Branch, jump and wrap
        applyStimulus(0, 0, 1, 0, 0, 16'h0000, 16'h0020);
        serveFetch(0, 16'h4444);
        applyStimulus(0, 0, 0, 1, 0, 16'hFFF0, 16'h0000);
        serveFetch(0, 16'h5555);
        applyStimulus(0, 0, 1, 0, 0, 16'h0004, 16'h1000);
        serveFetch(0, 16'h6666);
        applyStimulus(0, 0, 1, 0, 0, 16'h0000, 16'hFFFE);
        serveFetch(1, 16'h7777);
        applyStimulus(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        serveFetch(0, 16'h8888);

        // Interrupt round trip; siic overrides the coincident halt
        applyStimulus(0, 0, 1, 0, 0, 16'h0000, 16'h0040);
        serveFetch(0, 16'h9999);
        applyStimulus(1, 0, 0, 0, 1, 16'h0000, 16'h0000);
        serveFetch(0, 16'hAAAA);
        applyStimulus(0, 1, 0, 0, 0, 16'h0000, 16'h0000);
        serveFetch(0, 16'hBBBB);

        // Halt at 0x0030, then ignored retire pulses
        applyStimulus(0, 0, 1, 0, 0, 16'h0000, 16'h0030);
        serveFetch(0, 16'hCCCC);
        applyStimulus(0, 0, 0, 0, 1, 16'h0000, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            retire  = 1'b1;
            reg_jmp = 1'b1;
            rs_val  = 16'h0500;
            imem_done = 1'b1;
            @(negedge clk);
            checkOutput("hold_halted", {15'd0, halted}, 16'd1);
            checkOutput("hold_imem_en", {15'd0, imem_en}, 16'd0);
            checkOutput("hold_pc", imem_addr, 16'h0032);
            checkOutput("hold_valid", {15'd0, instr_valid}, 16'd0);
        end
        imem_done = 1'b0;
        clearControls();

        // Misaligned jump target
        doReset();
        serveFetch(0, 16'h1234);
        applyStimulus(0, 0, 1, 0, 0, 16'h0001, 16'h0100);
        checkOutput("err_pc", imem_addr, 16'h0100);

        // Reset while halted with an error clears the sticky flag at once
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_err_clear", {15'd0, fetch_err}, 16'd0);
        checkOutput("async_halt_clear", {15'd0, halted}, 16'd0);
        doReset();

        // Asynchronous reset mid-FETCH
        serveFetch(0, 16'h4321);
        applyStimulus(0, 0, 1, 0, 0, 16'h0000, 16'h0050);
        imem_stall = 1'b1;
        @(negedge clk);
        checkOutput("midfetch_addr", imem_addr, 16'h0050);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_pc", imem_addr, 16'h0000);
        checkOutput("async_en", {15'd0, imem_en}, 16'd0);
        checkOutput("async_err", {15'd0, fetch_err}, 16'd0);
        doReset();
        serveFetch(0, 16'h0F0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
